// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: bus structs, bus encodings and cache state shared by the icache slice
package icache_direct_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;
  typedef struct packed {
    logic        okay;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  typedef enum logic [1:0] {IDLE, FETCH, READY} icache_state_t;
endpackage

// File: rtl/icache_direct_data_ram.sv
// icache_direct_data_ram: line data storage, one synchronous write port and one asynchronous read port
module icache_direct_data_ram #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  localparam int AW = $clog2(NUM_LINES * LINE_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [NUM_LINES * LINE_WORDS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with single-burst line refill
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFS = WB + 2;
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = 32 - OFS - IDX;
  icache_state_t state, state_nxt;
  logic [NUM_LINES-1:0] valid;
  logic [TAG-1:0] tags [NUM_LINES];
  logic [IDX-1:0] idx, miss_idx;
  logic [TAG-1:0] tag, miss_tag;
  logic [WB-1:0] word, cnt;
  logic [31:0] rdata;
  logic hit, miss, fill_we, fill_done, unused_addr;
  assign word = ireq.addr[OFS-1:2];
  assign idx = ireq.addr[OFS+IDX-1:OFS];
  assign tag = ireq.addr[31:OFS+IDX];
  assign unused_addr = &{1'b0, ireq.addr[1:0]};
  assign hit = state == IDLE && ireq.valid && valid[idx] && tags[idx] == tag;
  assign miss = state == IDLE && ireq.valid && !hit;
  assign fill_we = state == FETCH && cresp.okay;
  assign fill_done = fill_we && cresp.last;
  icache_direct_data_ram #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) u_ram (
    .clk(clk),
    .we(fill_we),
    .waddr({miss_idx, cnt}),
    .wdata(cresp.data),
    .raddr({idx, word}),
    .rdata(rdata)
  );
  always_comb begin
    state_nxt = state == IDLE ? (miss ? FETCH : IDLE) : state == FETCH ? (fill_done ? READY : FETCH) : IDLE;
    iresp = '0;
    iresp.addr_ok = hit;
    iresp.data_ok = hit;
    iresp.data = hit ? rdata : '0;
    creq = '0;
    creq.valid = state == FETCH;
    creq.size = state == FETCH ? MSIZE4 : MSIZE1;
    creq.addr = state == FETCH ? {miss_tag, miss_idx, OFS'(0)} : '0;
    creq.len = state == FETCH ? mlen_t'(4'(LINE_WORDS - 1)) : MLEN1;
  end
  // the line being refilled is invalidated up front so a partial fill is never visible
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (miss) valid[idx] <= 1'b0;
      if (fill_we) cnt <= cnt + 1'b1;
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        cnt <= '0;
      end
    end
  always_ff @(posedge clk) begin
    if (miss) begin
      miss_idx <= idx;
      miss_tag <= tag;
    end
    if (fill_done) tags[miss_idx] <= miss_tag;
  end
  assert property (@(posedge clk) disable iff (reset) fill_done |-> cnt == WB'(LINE_WORDS - 1));
endmodule
